// File: rtl/can_pkg.sv
// Shared CAN transmit-path types: field widths, mailbox record and the
// transmit sequencer state encoding.
package can_pkg;

    localparam int CAN_ID_W    = 11;
    localparam int CAN_FRAME_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } can_tx_state_e;

    typedef struct packed {
        logic [CAN_ID_W-1:0]    id;
        logic [CAN_FRAME_W-1:0] data;
    } can_mb_t;

    // Strictly-lower identifier wins, so equal identifiers keep the earlier candidate.
    function automatic logic id_beats(input logic [CAN_ID_W-1:0] cand,
                                      input logic [CAN_ID_W-1:0] best);
        return (cand < best);
    endfunction

endpackage

// File: rtl/can_mb_arbiter.sv
// Combinational priority search: among requesting entries pick the lowest
// identifier, ties resolved toward the lowest index.
module can_mb_arbiter
    import can_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]               req,
    input  logic [N-1:0][CAN_ID_W-1:0] ids,
    output logic [IW-1:0]              win_idx,
    output logic                       win_valid
);

    logic [CAN_ID_W-1:0] best_id_s;
    logic                take_s;

    // Linear scan from index 0 upward; a later entry only displaces the
    // current best with a strictly lower identifier.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        best_id_s = '1;
        take_s    = 1'b0;
        for (int i = 0; i < N; i++) begin
            take_s    = req[i] && (!win_valid || id_beats(ids[i], best_id_s));
            win_idx   = take_s ? IW'(i) : win_idx;
            best_id_s = take_s ? ids[i] : best_id_s;
            win_valid = win_valid | take_s;
        end
    end

endmodule

// File: rtl/can_tx_mailbox.sv
// Host-loaded transmit mailboxes with ID arbitration, a per-attempt TXOK
// timeout, bounded retry, abort and completion/error reporting.
module can_tx_mailbox
    import can_pkg::*;
#(
    parameter int  NUM_MB    = 4,
    parameter int  TIMEOUT   = 20000,
    parameter int  MAX_RETRY = 3,
    localparam int IW        = $clog2(NUM_MB)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   wr_en,
    input  logic [IW-1:0]          wr_idx,
    input  logic [CAN_ID_W-1:0]    wr_id,
    input  logic [CAN_FRAME_W-1:0] wr_data,
    input  logic                   abort_en,
    input  logic [IW-1:0]          abort_idx,
    output logic [CAN_FRAME_W-1:0] tx_message,
    output logic                   tx_en,
    input  logic                   TXOK,
    output logic [NUM_MB-1:0]      pending,
    output logic [IW-1:0]          busy_idx,
    output logic                   done_pulse,
    output logic                   err_pulse,
    output logic                   abort_pulse,
    output logic                   wr_reject
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    can_tx_state_e                   state_r;
    can_tx_state_e                   state_next_s;
    can_mb_t                         mb_r [NUM_MB];
    logic [NUM_MB-1:0]               pending_r;
    logic [NUM_MB-1:0]               pending_next_s;
    logic [IW-1:0]                   busy_idx_r;
    logic [CAN_FRAME_W-1:0]          tx_message_r;
    logic                            tx_en_r;
    logic                            done_r;
    logic                            err_r;
    logic                            abort_r;
    logic                            wr_reject_r;
    logic [TW-1:0]                   tmo_cnt_r;
    logic [RW-1:0]                   retry_r;
    logic [RW-1:0]                   retry_inc_s;
    logic                            ev_ok_s;
    logic                            ev_abort_s;
    logic                            ev_tmo_s;
    logic                            ev_drop_s;
    logic                            wr_reject_s;
    logic                            wr_accept_s;
    logic [NUM_MB-1:0][CAN_ID_W-1:0] ids_s;
    logic [IW-1:0]                   win_idx_s;
    logic                            win_valid_s;

    assign tx_message  = tx_message_r;
    assign tx_en       = tx_en_r;
    assign pending     = pending_r;
    assign busy_idx    = busy_idx_r;
    assign done_pulse  = done_r;
    assign err_pulse   = err_r;
    assign abort_pulse = abort_r;
    assign wr_reject   = wr_reject_r;

    // Only the mailbox on the wire is write-protected; all others accept updates.
    assign wr_reject_s = wr_en && (state_r == SEND) && (wr_idx == busy_idx_r);
    assign wr_accept_s = wr_en && !wr_reject_s;
    assign retry_inc_s = retry_r + RW'(1'b1);
    assign ev_drop_s   = ev_tmo_s && (retry_inc_s == RW'(MAX_RETRY));

    // Gather identifiers into a packed vector for the arbiter.
    always_comb begin
        ids_s = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            ids_s[i] = mb_r[i].id;
        end
    end

    can_mb_arbiter #(
        .N  (NUM_MB),
        .IW (IW)
    ) u_arbiter (
        .req       (pending_r),
        .ids       (ids_s),
        .win_idx   (win_idx_s),
        .win_valid (win_valid_s)
    );

    // Next-state logic; SEND exits are prioritised TXOK, then abort, then timeout.
    always_comb begin
        state_next_s = state_r;
        ev_ok_s      = 1'b0;
        ev_abort_s   = 1'b0;
        ev_tmo_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (|pending_r) begin
                    state_next_s = ARB;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARB: begin
                // An abort during IDLE can empty the mask before arbitration.
                if (win_valid_s) begin
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (TXOK) begin
                    ev_ok_s      = 1'b1;
                    state_next_s = GAP;
                end else if (abort_en && (abort_idx == busy_idx_r)) begin
                    ev_abort_s   = 1'b1;
                    state_next_s = GAP;
                end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
                    ev_tmo_s     = 1'b1;
                    state_next_s = GAP;
                end else begin
                    state_next_s = SEND;
                end
            end
            GAP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Pending mask update: a host write beats any clear in the same cycle.
    always_comb begin
        pending_next_s = pending_r;
        for (int i = 0; i < NUM_MB; i++) begin
            pending_next_s[i] =
                (wr_accept_s && (wr_idx == IW'(i))) ? 1'b1 :
                (((busy_idx_r == IW'(i)) && (ev_ok_s || ev_abort_s || ev_drop_s)) ||
                 (abort_en && (abort_idx == IW'(i)))) ? 1'b0 : pending_r[i];
        end
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Control registers, counters, frame latch and pulse outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pending_r    <= '0;
            busy_idx_r   <= '0;
            tx_message_r <= '0;
            tx_en_r      <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            abort_r      <= 1'b0;
            wr_reject_r  <= 1'b0;
            tmo_cnt_r    <= '0;
            retry_r      <= '0;
        end else begin
            pending_r   <= pending_next_s;
            tx_en_r     <= (state_next_s == SEND);
            done_r      <= ev_ok_s;
            err_r       <= ev_drop_s;
            abort_r     <= ev_abort_s;
            wr_reject_r <= wr_reject_s;
            case (state_r)
                ARB: begin
                    tmo_cnt_r <= '0;
                    if (win_valid_s) begin
                        busy_idx_r   <= win_idx_s;
                        tx_message_r <= mb_r[win_idx_s].data;
                        // A different winner starts its own retry budget.
                        if (win_idx_s != busy_idx_r) begin
                            retry_r <= '0;
                        end
                    end
                end
                SEND: begin
                    tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
                    if (ev_ok_s) begin
                        retry_r <= '0;
                    end else if (ev_tmo_s) begin
                        retry_r <= ev_drop_s ? RW'(1'b0) : retry_inc_s;
                    end
                end
                default: begin
                    tmo_cnt_r <= tmo_cnt_r;
                end
            endcase
        end
    end

    // Mailbox storage; contents need no reset since pending gates their use.
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < NUM_MB; i++) begin
            if (wr_accept_s && (wr_idx == IW'(i))) begin
                mb_r[i] <= '{id: wr_id, data: wr_data};
            end
        end
    end

endmodule
